// File: rtl/rx_bit_timer.sv
// USB receive bit timer: phase counter resynced on every D+ edge, strobes samples and counts bits into bytes.
// Latency: shift_enable decoded from registers at phase SAMPLE_PT; byte_received one cycle after the last sample.
// Backpressure: none, the strobes are free-running while enabled; optional stuffed-bit skip via RX_STUFF_SKIP_EN.
module rx_bit_timer #(
  parameter int CLKS_PER_BIT  = 8,
  parameter int SAMPLE_PT     = 3,
  parameter int BITS_PER_BYTE = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       enable_timer,
  input  logic       d_edge,
  output logic       shift_enable,
  output logic       byte_received,
  output logic [3:0] bit_count,
  output logic       timer_active
);

  localparam int PW = $clog2(CLKS_PER_BIT);

  localparam logic [PW-1:0] PH_ZERO   = '0;
  localparam logic [PW-1:0] PH_ONE    = PW'(1);
  localparam logic [PW-1:0] PH_LAST   = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(SAMPLE_PT);
  localparam logic [3:0]    BC_LAST   = 4'(BITS_PER_BYTE - 1);

  generate
    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 16) begin : g_bad_clks
      $error("rx_bit_timer: CLKS_PER_BIT out of range 4..16");
    end
    if (SAMPLE_PT <= 0 || SAMPLE_PT >= CLKS_PER_BIT) begin : g_bad_sample
      $error("rx_bit_timer: SAMPLE_PT must lie strictly inside the bit period");
    end
    if (BITS_PER_BYTE < 1 || BITS_PER_BYTE > 15) begin : g_bad_bits
      $error("rx_bit_timer: BITS_PER_BYTE out of range 1..15");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          byte_q, byte_d;
  logic          sample_pt;
  logic          skip;
  logic          clear;

  // Dropping enable wins over everything, including a byte completing this cycle.
  assign clear = !enable_timer || (state_q == IDLE);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable_timer) state_d = ARMED;
      end
      ARMED: begin
        if (!enable_timer)  state_d = IDLE;
        else if (d_edge)    state_d = RUN;
      end
      RUN: begin
        if (!enable_timer)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sample_pt     = (state_q == RUN) && (phase_q == PH_SAMPLE);
    shift_enable  = sample_pt && !skip;
    timer_active  = (state_q == RUN);
    byte_received = byte_q;
    bit_count     = bit_cnt_q;
  end

  always_comb begin
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = 1'b0;
    if (clear) begin
      phase_d   = PH_ZERO;
      bit_cnt_d = '0;
    end else if (state_q == ARMED) begin
      // The entering edge cycle counts as phase 0.
      phase_d = d_edge ? PH_ONE : PH_ZERO;
    end else begin
      if (d_edge)                  phase_d = PH_ONE;
      else if (phase_q == PH_LAST) phase_d = PH_ZERO;
      else                         phase_d = phase_q + PH_ONE;
      if (shift_enable) begin
        if (bit_cnt_q == BC_LAST) begin
          bit_cnt_d = '0;
          byte_d    = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q   <= PH_ZERO;
      bit_cnt_q <= '0;
      byte_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
    end
  end

`ifdef RX_STUFF_SKIP_EN
  logic       edge_seen_q, edge_seen_d;
  logic [2:0] ones_q, ones_d;
  logic       bit_val;

  // A bit with no transition inside its period is a 1 (NRZI); six in a row means the next is stuffed.
  always_comb begin
    bit_val     = !(edge_seen_q || d_edge);
    skip        = sample_pt && (ones_q == 3'd6);
    edge_seen_d = edge_seen_q;
    ones_d      = ones_q;
    if (clear) begin
      edge_seen_d = 1'b0;
      ones_d      = 3'd0;
    end else if (sample_pt) begin
      edge_seen_d = 1'b0;
      if (skip)         ones_d = 3'd0;
      else if (bit_val) ones_d = ones_q + 3'd1;
      else              ones_d = 3'd0;
    end else if (d_edge) begin
      edge_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      edge_seen_q <= 1'b0;
      ones_q      <= 3'd0;
    end else begin
      edge_seen_q <= edge_seen_d;
      ones_q      <= ones_d;
    end
  end
`else
  assign skip = 1'b0;
`endif

endmodule

// File: tb/tb_rx_bit_timer.sv
// Scoreboard bench for rx_bit_timer: stimulus queues expected strobe cycles and status, a negedge monitor pops and compares.
// Cycle numbers count rising edges; inputs change 1 time unit after an edge and hold for that cycle.
module tb_rx_bit_timer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       enable_timer;
  logic       d_edge;
  logic       shift_enable;
  logic       byte_received;
  logic [3:0] bit_count;
  logic       timer_active;

  rx_bit_timer #(
    .CLKS_PER_BIT (8),
    .SAMPLE_PT    (3),
    .BITS_PER_BYTE(8)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable_timer (enable_timer),
    .d_edge       (d_edge),
    .shift_enable (shift_enable),
    .byte_received(byte_received),
    .bit_count    (bit_count),
    .timer_active (timer_active)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int c;
    int bc;
    int act;
  } st_t;

  int  exp_se[$];
  int  exp_br[$];
  st_t exp_st[$];
  st_t st_head;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic pulse_edge();
    d_edge = 1'b1;
    step(1);
    d_edge = 1'b0;
  endtask

  task automatic st_at(input int c, input int bc, input int act);
    st_t e;
    e.c   = c;
    e.bc  = bc;
    e.act = act;
    exp_st.push_back(e);
  endtask

  // Monitor: every strobe must match the head of its queue; status checks fire on their cycle.
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (shift_enable === 1'b1) begin
        if (exp_se.size() == 0) chk("shift_enable_unexpected", cyc, -1);
        else                    chk("shift_enable_cycle", cyc, exp_se.pop_front());
      end
      if (byte_received === 1'b1) begin
        if (exp_br.size() == 0) chk("byte_received_unexpected", cyc, -1);
        else                    chk("byte_received_cycle", cyc, exp_br.pop_front());
      end
      while (exp_st.size() > 0 && exp_st[0].c <= cyc) begin
        st_head = exp_st.pop_front();
        chk("bit_count", int'(bit_count), st_head.bc);
        chk("timer_active", int'(timer_active), st_head.act);
      end
    end
  end

  int t;
  int base;
  int d;

  initial begin
    n_rst        = 1'b0;
    enable_timer = 1'b0;
    d_edge       = 1'b0;
    #2;
    chk("reset_shift_enable", int'(shift_enable), 0);
    chk("reset_byte_received", int'(byte_received), 0);
    chk("reset_bit_count", int'(bit_count), 0);
    chk("reset_timer_active", int'(timer_active), 0);
    step(2);
    n_rst = 1'b1;
    step(2);

    // Free-running byte from a single edge, then clear.
    enable_timer = 1'b1;
    step(1);
    t = cyc;
    st_at(t, 0, 0);
    st_at(t + 1, 0, 1);
    st_at(t + 4, 1, 1);
    st_at(t + 52, 7, 1);
`ifndef RX_STUFF_SKIP_EN
    for (int k = 0; k <= 8; k++) exp_se.push_back(t + 3 + 8 * k);
    exp_br.push_back(t + 60);
    st_at(t + 60, 0, 1);
    st_at(t + 68, 1, 1);
`else
    for (int k = 0; k <= 6; k++) exp_se.push_back(t + 3 + 8 * k);
    exp_se.push_back(t + 67);
    exp_br.push_back(t + 68);
    st_at(t + 60, 7, 1);
    st_at(t + 68, 0, 1);
`endif
    st_at(t + 73, 0, 0);
    pulse_edge();
    wait_until(t + 72);
    enable_timer = 1'b0;
    step(1);
    step(3);

    // Resync at phase 6, edge landing on a sample point, then clear after 5 samples.
    enable_timer = 1'b1;
    step(1);
    t = cyc;
    exp_se.push_back(t + 3);
    exp_se.push_back(t + 9);
    exp_se.push_back(t + 17);
    exp_se.push_back(t + 20);
    exp_se.push_back(t + 28);
    st_at(t + 8, 1, 1);
    st_at(t + 18, 3, 1);
    st_at(t + 29, 5, 1);
    st_at(t + 30, 0, 0);
    pulse_edge();
    wait_until(t + 6);
    pulse_edge();
    wait_until(t + 17);
    pulse_edge();
    wait_until(t + 29);
    enable_timer = 1'b0;
    step(1);
    step(3);

    // Asynchronous reset mid-byte, then re-enable waits for a fresh edge.
    enable_timer = 1'b1;
    step(1);
    t = cyc;
    for (int k = 0; k < 4; k++) exp_se.push_back(t + 3 + 8 * k);
    st_at(t + 28, 4, 1);
    pulse_edge();
    wait_until(t + 30);
    #2;
    n_rst = 1'b0;
    #1;
    chk("async_rst_shift_enable", int'(shift_enable), 0);
    chk("async_rst_byte_received", int'(byte_received), 0);
    chk("async_rst_bit_count", int'(bit_count), 0);
    chk("async_rst_timer_active", int'(timer_active), 0);
    enable_timer = 1'b0;
    step(1);
    n_rst = 1'b1;
    step(2);
    enable_timer = 1'b1;
    step(1);
    base = cyc;
    for (int k = 0; k < 20; k++) st_at(base + k, 0, 0);
    wait_until(base + 20);
    t = cyc;
    exp_se.push_back(t + 3);
    st_at(t + 4, 1, 1);
    pulse_edge();
    wait_until(t + 6);
    enable_timer = 1'b0;
    step(1);
    step(3);

    // Clear in the same cycle the byte completes: no byte_received.
    enable_timer = 1'b1;
    step(1);
    t = cyc;
`ifndef RX_STUFF_SKIP_EN
    d = t + 59;
    for (int k = 0; k <= 7; k++) exp_se.push_back(t + 3 + 8 * k);
`else
    d = t + 67;
    for (int k = 0; k <= 6; k++) exp_se.push_back(t + 3 + 8 * k);
    exp_se.push_back(t + 67);
`endif
    st_at(d, 7, 1);
    st_at(d + 1, 0, 0);
    pulse_edge();
    wait_until(d);
    enable_timer = 1'b0;
    step(1);
    step(6);

    chk("shift_enable_missing", exp_se.size(), 0);
    chk("byte_received_missing", exp_br.size(), 0);
    chk("status_missing", exp_st.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
